// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: shift-add multiplier and restoring divider sharing one adder.
// Holds the pipeline via busy; done pulses once when result is valid.
module muldiv_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct_3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [CW-1:0] CntLast = CW'(XLEN - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     mcand_q, mcand_d;
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     result_q, result_d;

   // operand conditioning on the raw inputs
   logic            is_div_in, sgn_a_in, sgn_b_in, neg_a, neg_b;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b, special_res;

   always_comb begin
      is_div_in = funct_3[2];
      sgn_a_in  = funct_3 inside {3'd1, 3'd2, 3'd4, 3'd6};
      sgn_b_in  = funct_3 inside {3'd1, 3'd4, 3'd6};
      neg_a     = sgn_a_in & op_a[XLEN-1];
      neg_b     = sgn_b_in & op_b[XLEN-1];
      mag_a     = neg_a ? (~op_a + XLEN'(1)) : op_a;
      mag_b     = neg_b ? (~op_b + XLEN'(1)) : op_b;
      div_zero  = is_div_in && (op_b == '0);
      div_ovf   = is_div_in && !funct_3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (op_b == '1);
      // overflow: DIV returns the dividend itself, REM returns zero
      if (div_zero) special_res = funct_3[1] ? op_a : '1;
      else          special_res = funct_3[1] ? '0 : op_a;
   end

   // shared adder: add for multiply, trial subtract for divide
   logic [XLEN+1:0] add_x, add_y, add_sum;
   logic            add_sub;
   logic [XLEN:0]   rem_sh;

   always_comb begin
      rem_sh = acc_q[2*XLEN-1:XLEN-1];
      if (op_q[2]) begin
         add_x   = {1'b0, rem_sh};
         add_y   = {2'b00, mcand_q};
         add_sub = 1'b1;
      end else begin
         add_x   = {2'b00, acc_q[2*XLEN-1:XLEN]};
         add_y   = acc_q[0] ? {2'b00, mcand_q} : '0;
         add_sub = 1'b0;
      end
      add_sum = add_x + (add_sub ? ~add_y : add_y) + {{(XLEN+1){1'b0}}, add_sub};
   end

   // final sign correction and selection
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   div_val, div_fix, fix_res;

   always_comb begin
      prod_fix = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
      div_val  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      div_fix  = neg_q ? (~div_val + XLEN'(1)) : div_val;
      if (op_q[2])           fix_res = div_fix;
      else if (op_q == 3'd0) fix_res = prod_fix[XLEN-1:0];
      else                   fix_res = prod_fix[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (start && !flush) begin
               op_d  = funct_3;
               neg_d = (funct_3 == 3'd6) ? neg_a : (neg_a ^ neg_b);
               cnt_d = '0;
               if (div_zero || div_ovf) begin
                  result_d = special_res;
                  state_d  = StDone;
               end else begin
                  state_d = StCalc;
                  // divide: dividend in low half; multiply: multiplier in low half
                  acc_d   = {{XLEN{1'b0}}, is_div_in ? mag_a : mag_b};
                  mcand_d = is_div_in ? mag_b : mag_a;
               end
            end
         end
         StCalc: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               if (op_q[2]) begin
                  if (add_sum[XLEN+1])
                     acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                  else
                     acc_d = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
               end else begin
                  acc_d = {add_sum[XLEN:0], acc_q[XLEN-1:1]};
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CntLast) state_d = StFix;
            end
         end
         StFix: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               result_d = fix_res;
               state_d  = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == StCalc) || (state_q == StFix);
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule
